elevator_sequencer: RTL and testbench
=====================================

Name: elevator_sequencer

Overview:
- Controller for the floor-step datapath (`nextfloor`). Latches hall/car calls, picks a travel direction, and drives the datapath's direction select. It also registers the stepped floor value and times travel and door intervals.
- Sits between the request inputs (buttons/switch debouncers) and the floor display/datapath. It owns the current-floor register that feeds `nextfloor.floor`.

Parameters:
- NUM_FLOORS, 8, number of served floors (2..8); floor indices are 0..NUM_FLOORS-1 on a 3-bit bus.
- TRAVEL_CYCLES, 4, clock cycles spent travelling between adjacent floors (>=1).
- DOOR_CYCLES, 3, clock cycles the door stays open per stop (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_FLOORS  call pulses; bit i = request for floor i; may be held or pulsed; multiple bits may be set at once.
- next_floor  input  3  stepped value returned by the `nextfloor` datapath (floor+1 or floor-1).
- floor  output  3  current floor register; drives the datapath floor input.
- mux_sig  output  1  direction select to the datapath: 1 = up, 0 = down.
- moving  output  1  high while in MOVE state.
- door_open  output  1  high while in DOOR state.
- pending  output  NUM_FLOORS  latched outstanding requests.

Behaviour:
- Reset (async, immediate): floor=0, mux_sig=1, moving=0, door_open=0, pending=0, state=IDLE, timers=0. Reset mid-travel or mid-door abandons all requests.
- All outputs are registered. States are IDLE, MOVE, DOOR.
- Request latching: pending[i] is set at the edge where req[i]=1, except while in DOOR when i==floor.
  - That exception reloads the door timer instead of latching.
  - Set and clear on the same bit in the same cycle: clear wins only for the floor being opened on that edge.
- Direction decision uses "above" = any pending bit above floor and "below" = any pending bit below floor.
  - Prefer the current mux_sig direction if requests exist that way; otherwise take the other direction.
- IDLE:
  - pending[floor]=1: go to DOOR next edge and clear pending[floor].
  - Else if above or below: set mux_sig per the direction rule, go to MOVE and load the travel timer.
  - Else stay in IDLE.
  - Latency: req at edge N gives pending at N, then moving=1 or door_open=1 after edge N+1.
- MOVE:
  - The timer counts TRAVEL_CYCLES cycles.
  - mux_sig is held constant for the whole travel interval and never changes mid-travel.
  - On the terminal cycle, floor <= next_floor.
  - At the new floor f, within the same edge:
    - pending[f]: go to DOOR and clear pending[f].
    - Else if requests remain in the current direction: stay in MOVE and reload the timer.
    - Else if requests exist the other way: flip mux_sig and stay in MOVE.
    - Else go to IDLE.
- DOOR:
  - door_open=1 for DOOR_CYCLES cycles.
  - A req for the current floor reloads the timer to DOOR_CYCLES.
  - On expiry, go to IDLE; the next decision happens in IDLE one cycle later.
- Boundaries:
  - Motion only targets pending floors, so floor never leaves 0..NUM_FLOORS-1.
  - Illegal (bench asserts): moving with mux_sig=1 at floor NUM_FLOORS-1, or moving with mux_sig=0 at floor 0.
  - Wrap-around of the 3-bit datapath must never be consumed.
  - req bits map only to valid floors, since the port width is NUM_FLOORS.

Test Plan:
- After reset, pulse req[3] -> pending=8'h08; moving=1, mux_sig=1 one edge later; floor steps 0→1→2→3 at 4-cycle intervals; door_open=1 for 3 cycles; pending=0; then idle at floor 3.
- Idle at 3 with last mux_sig=1, pulse req[5] and req[1] together -> serves 5 first (door), then mux_sig=0, travels down to 1; pending=0 at end.
- Travelling up from 0 toward 5, pulse req[2] during the 0→1 leg -> stops at 2 (door 3 cycles, pending[2] cleared), then continues to 5.
- Idle at 4, pulse req[4] -> door_open next edge, floor unchanged. Pulse req[4] again on the 2nd door cycle -> door stays open 3 further cycles; pending[4] stays 0.
- Assert reset mid-travel (floor=2, moving=1) -> floor=0, moving=0, door_open=0, pending=0 immediately, without waiting for a clock edge.
- Drive to floor 7, then pulse req[7] -> door only, no motion. Assertion checks mux_sig never 1 while moving at floor 7, nor 0 while moving at floor 0, across a random request soak.

Source files
------------

// File: rtl/elevator_sequencer.sv
// Elevator call sequencer: latches floor calls, chooses travel direction for the
// nextfloor datapath, owns the current-floor register and times travel/door intervals.
module elevator_sequencer #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [2:0]            next_floor,
  output logic [2:0]            floor,
  output logic                  mux_sig,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  // state | meaning
  // IDLE  | parked with doors closed, evaluating pending calls every cycle
  // MOVE  | travelling one floor per TRAVEL_CYCLES toward a pending call
  // DOOR  | doors open for DOOR_CYCLES; a call for this floor restarts the interval
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int TT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TT_W-1:0] TRAVEL_LOAD = TT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DT_W-1:0] DOOR_LOAD   = DT_W'(DOOR_CYCLES - 1);

  state_t                state, state_n;
  logic [2:0]            floor_n;
  logic                  mux_n;
  logic [NUM_FLOORS-1:0] pending_n;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic [TT_W-1:0]       travel_cnt, travel_n;
  logic [DT_W-1:0]       door_cnt, door_n;

  logic [NUM_FLOORS-1:0] cur_mask, nxt_mask;
  logic                  cur_here, cur_above, cur_below;
  logic                  nxt_here, nxt_above, nxt_below;

  function automatic logic [NUM_FLOORS-1:0] eq_mask(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (3'(i) == f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] gt_mask(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (3'(i) > f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] lt_mask(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (3'(i) < f);
    return m;
  endfunction

  // Decisions in IDLE look at the current floor; at the end of a travel leg they
  // look at the floor being arrived at, which is next_floor on that edge.
  assign cur_mask  = eq_mask(floor);
  assign cur_here  = |(pending & cur_mask);
  assign cur_above = |(pending & gt_mask(floor));
  assign cur_below = |(pending & lt_mask(floor));

  assign nxt_mask  = eq_mask(next_floor);
  assign nxt_here  = |(pending & nxt_mask);
  assign nxt_above = |(pending & gt_mask(next_floor));
  assign nxt_below = |(pending & lt_mask(next_floor));

  always_comb begin
    state_n  = state;
    floor_n  = floor;
    mux_n    = mux_sig;
    travel_n = travel_cnt;
    door_n   = door_cnt;
    clr_mask = '0;
    set_mask = req;

    // A call for the open floor only extends the door; it is never latched.
    if (state == DOOR) set_mask = req & ~cur_mask;

    case (state)
      IDLE: begin
        if (cur_here) begin
          state_n  = DOOR;
          door_n   = DOOR_LOAD;
          clr_mask = cur_mask;
        end else if (cur_above || cur_below) begin
          state_n  = MOVE;
          travel_n = TRAVEL_LOAD;
          // keep heading the same way while calls remain there
          mux_n    = mux_sig ? cur_above : ~cur_below;
        end
      end

      MOVE: begin
        if (travel_cnt != '0) begin
          travel_n = travel_cnt - TT_W'(1);
        end else begin
          floor_n = next_floor;
          if (nxt_here) begin
            state_n  = DOOR;
            door_n   = DOOR_LOAD;
            clr_mask = nxt_mask;
          end else if (mux_sig ? nxt_above : nxt_below) begin
            travel_n = TRAVEL_LOAD;
          end else if (mux_sig ? nxt_below : nxt_above) begin
            travel_n = TRAVEL_LOAD;
            mux_n    = ~mux_sig;
          end else begin
            state_n = IDLE;
          end
        end
      end

      DOOR: begin
        if (|(req & cur_mask)) begin
          door_n = DOOR_LOAD;
        end else if (door_cnt == '0) begin
          state_n = IDLE;
        end else begin
          door_n = door_cnt - DT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    // clear wins over a simultaneous set only for the floor being opened
    pending_n = (pending | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      floor      <= 3'd0;
      mux_sig    <= 1'b1;
      pending    <= '0;
      travel_cnt <= '0;
      door_cnt   <= '0;
      moving     <= 1'b0;
      door_open  <= 1'b0;
    end else begin
      state      <= state_n;
      floor      <= floor_n;
      mux_sig    <= mux_n;
      pending    <= pending_n;
      travel_cnt <= travel_n;
      door_cnt   <= door_n;
      moving     <= (state_n == MOVE);
      door_open  <= (state_n == DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_sequencer.sv
// Scenario bench for elevator_sequencer: expected stop floors are queued with each
// call and compared as doors open; tasks check timing, reset and boundary behaviour.
module tb_elevator_sequencer;
  localparam int NF = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] req;
  logic [2:0]    next_floor;
  logic [2:0]    floor;
  logic          mux_sig;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit sb_en = 1'b1;

  always #5 clk = ~clk;

  // nextfloor datapath model
  assign next_floor = mux_sig ? floor + 3'd1 : floor - 3'd1;

  elevator_sequencer #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .req(req), .next_floor(next_floor), .floor(floor),
    .mux_sig(mux_sig), .moving(moving), .door_open(door_open), .pending(pending)
  );

  // Scoreboard for stop order plus motion invariants, sampled on the falling edge.
  logic       door_prev = 1'b0, mov_prev = 1'b0, mux_prev = 1'b1;
  logic [2:0] floor_prev = 3'd0;
  always @(negedge clk) begin
    if (reset) begin
      door_prev = 1'b0;
      mov_prev  = 1'b0;
    end else begin
      checks++;
      if (int'(floor) >= NF || (moving && mux_sig && floor == 3'(NF-1)) ||
          (moving && !mux_sig && floor == 3'd0)) begin
        errors++;
        $display("FAIL motion_bounds floor=%0d mux_sig=%0b moving=%0b", floor, mux_sig, moving);
      end
      if (moving && mov_prev) begin
        checks++;
        if (floor == floor_prev && mux_sig !== mux_prev) begin
          errors++;
          $display("FAIL mux_hold mux_sig=%0b was=%0b mid-leg at floor %0d", mux_sig, mux_prev, floor);
        end
      end
      if (sb_en && door_open && !door_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stop_unexpected got floor=%0d exp=none", floor);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(floor) !== e) begin
            errors++;
            $display("FAIL stop_floor got=%0d exp=%0d", floor, e);
          end
        end
      end
      door_prev  = door_open;
      mov_prev   = moving;
      mux_prev   = mux_sig;
      floor_prev = floor;
    end
  end

  task automatic pulse(input logic [NF-1:0] m);
    @(negedge clk);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!moving && !door_open && pending == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = '0;
    repeat (3) @(negedge clk);
    checks++; if (floor !== 3'd0)   begin errors++; $display("FAIL reset_floor got=%0d exp=0", floor); end
    checks++; if (mux_sig !== 1'b1) begin errors++; $display("FAIL reset_mux got=%0b exp=1", mux_sig); end
    checks++; if (moving !== 1'b0)  begin errors++; $display("FAIL reset_moving got=%0b exp=0", moving); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door got=%0b exp=0", door_open); end
    checks++; if (pending !== '0)   begin errors++; $display("FAIL reset_pending got=%h exp=00", pending); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (moving !== 1'b0 || door_open !== 1'b0 || floor !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle got moving=%0b door=%0b floor=%0d exp 0/0/0", moving, door_open, floor);
    end
  endtask

  task automatic test_single_up;
    exp_q.push_back(3);
    pulse(8'h08);
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL up_pending got=%h exp=08", pending); end
    checks++; if (moving !== 1'b0)   begin errors++; $display("FAIL up_latency got moving=%0b exp=0", moving); end
    @(negedge clk);
    checks++;
    if (moving !== 1'b1 || mux_sig !== 1'b1 || floor !== 3'd0) begin
      errors++;
      $display("FAIL up_start got moving=%0b mux=%0b floor=%0d exp 1/1/0", moving, mux_sig, floor);
    end
    repeat (3) @(negedge clk);
    checks++; if (floor !== 3'd0) begin errors++; $display("FAIL up_leg1_hold got=%0d exp=0", floor); end
    @(negedge clk);
    checks++; if (floor !== 3'd1) begin errors++; $display("FAIL up_floor1 got=%0d exp=1", floor); end
    repeat (4) @(negedge clk);
    checks++; if (floor !== 3'd2) begin errors++; $display("FAIL up_floor2 got=%0d exp=2", floor); end
    repeat (4) @(negedge clk);
    checks++;
    if (floor !== 3'd3 || door_open !== 1'b1 || moving !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL up_arrive got floor=%0d door=%0b moving=%0b pend=%h exp 3/1/0/00",
               floor, door_open, moving, pending);
    end
    repeat (2) @(negedge clk);
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL up_door_len3 got=%0b exp=1", door_open); end
    @(negedge clk);
    checks++;
    if (door_open !== 1'b0 || moving !== 1'b0 || floor !== 3'd3) begin
      errors++;
      $display("FAIL up_idle got door=%0b moving=%0b floor=%0d exp 0/0/3", door_open, moving, floor);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL up_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_two_calls;
    bit ok;
    exp_q.push_back(5);
    exp_q.push_back(1);
    pulse(8'h22);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_timeout got=busy exp=idle"); end
    checks++;
    if (floor !== 3'd1 || mux_sig !== 1'b0) begin
      errors++;
      $display("FAIL two_end got floor=%0d mux=%0b exp 1/0", floor, mux_sig);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL two_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_intermediate;
    bit ok;
    bit seen;
    exp_q.push_back(0);
    pulse(8'h01);
    wait_idle(200, ok);
    checks++; if (!ok || floor !== 3'd0) begin errors++; $display("FAIL mid_home got floor=%0d ok=%0b exp 0/1", floor, ok); end
    exp_q.push_back(2);
    exp_q.push_back(5);
    pulse(8'h20);
    @(negedge clk);
    checks++;
    if (moving !== 1'b1 || mux_sig !== 1'b1 || floor !== 3'd0) begin
      errors++;
      $display("FAIL mid_start got moving=%0b mux=%0b floor=%0d exp 1/1/0", moving, mux_sig, floor);
    end
    pulse(8'h04);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (door_open) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || floor !== 3'd2 || pending !== 8'h20) begin
      errors++;
      $display("FAIL mid_stop2 got seen=%0b floor=%0d pend=%h exp 1/2/20", seen, floor, pending);
    end
    wait_idle(300, ok);
    checks++; if (!ok || floor !== 3'd5) begin errors++; $display("FAIL mid_end got floor=%0d ok=%0b exp 5/1", floor, ok); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_door_reload;
    bit ok;
    exp_q.push_back(4);
    pulse(8'h10);
    wait_idle(200, ok);
    checks++; if (!ok || floor !== 3'd4) begin errors++; $display("FAIL dr_setup got floor=%0d ok=%0b exp 4/1", floor, ok); end
    exp_q.push_back(4);
    pulse(8'h10);
    checks++; if (pending !== 8'h10) begin errors++; $display("FAIL dr_pending got=%h exp=10", pending); end
    @(negedge clk);
    checks++;
    if (door_open !== 1'b1 || pending !== 8'h00 || floor !== 3'd4 || moving !== 1'b0) begin
      errors++;
      $display("FAIL dr_open got door=%0b pend=%h floor=%0d moving=%0b exp 1/00/4/0",
               door_open, pending, floor, moving);
    end
    pulse(8'h10);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (door_open !== 1'b1 || pending !== 8'h00) begin
        errors++;
        $display("FAIL dr_extend%0d got door=%0b pend=%h exp 1/00", k, door_open, pending);
      end
    end
    @(negedge clk);
    checks++;
    if (door_open !== 1'b0 || pending !== 8'h00 || floor !== 3'd4) begin
      errors++;
      $display("FAIL dr_close got door=%0b pend=%h floor=%0d exp 0/00/4", door_open, pending, floor);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL dr_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_travel;
    bit seen;
    sb_en = 1'b0;
    pulse(8'h01);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (moving && floor == 3'd2) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_reach got=none exp=moving at 2"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (floor !== 3'd0 || moving !== 1'b0 || door_open !== 1'b0 || pending !== '0 || mux_sig !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async got floor=%0d moving=%0b door=%0b pend=%h mux=%0b exp 0/0/0/00/1",
               floor, moving, door_open, pending, mux_sig);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (moving !== 1'b0 || floor !== 3'd0 || pending !== '0) begin
      errors++;
      $display("FAIL rst_mid_after got moving=%0b floor=%0d pend=%h exp 0/0/00", moving, floor, pending);
    end
    sb_en = 1'b1;
  endtask

  task automatic test_top_floor;
    bit ok;
    int moved;
    exp_q.push_back(7);
    pulse(8'h80);
    wait_idle(300, ok);
    checks++; if (!ok || floor !== 3'd7) begin errors++; $display("FAIL top_reach got floor=%0d ok=%0b exp 7/1", floor, ok); end
    exp_q.push_back(7);
    pulse(8'h80);
    checks++; if (pending !== 8'h80) begin errors++; $display("FAIL top_pending got=%h exp=80", pending); end
    moved = 0;
    @(negedge clk);
    checks++;
    if (door_open !== 1'b1 || floor !== 3'd7) begin
      errors++;
      $display("FAIL top_door got door=%0b floor=%0d exp 1/7", door_open, floor);
    end
    for (int i = 0; i < 8; i++) begin
      if (moving) moved++;
      @(negedge clk);
    end
    checks++; if (moved != 0 || floor !== 3'd7) begin errors++; $display("FAIL top_nomove got moved=%0d floor=%0d exp 0/7", moved, floor); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL top_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_soak;
    bit ok;
    sb_en = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      req = NF'($urandom & $urandom & $urandom);
    end
    @(negedge clk);
    req = '0;
    wait_idle(3000, ok);
    checks++;
    if (!ok || pending !== '0 || moving !== 1'b0) begin
      errors++;
      $display("FAIL soak_drain got ok=%0b pend=%h moving=%0b exp 1/00/0", ok, pending, moving);
    end
    sb_en = 1'b1;
  endtask

  initial begin
    req   = '0;
    reset = 1'b1;
    test_reset();
    test_single_up();
    test_two_calls();
    test_intermediate();
    test_door_reload();
    test_reset_mid_travel();
    test_top_floor();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
